// File: rtl/mem_result_checker.sv
// Pairs reference-model and DUT memory transactions in arrival order and reports mismatching pairs.
// Also keeps saturating match/error counters and sticky overflow/timeout flags for end-of-test checks.
package mem_result_checker_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } instruction_item_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        write;
  } data_item_t;

  typedef struct packed {
    instruction_item_t input_instruction;
    data_item_t        model_result;
    data_item_t        dut_result;
    logic [2:0]        error_champ;
  } error_data_item_t;
endpackage

module mem_result_checker
  import mem_result_checker_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mdl_valid,
  output logic              mdl_ready,
  input  instruction_item_t mdl_inst,
  input  data_item_t        mdl_res,
  input  logic              dut_valid,
  input  data_item_t        dut_res,
  output logic              err_valid,
  output error_data_item_t  err_item,
  output logic [31:0]       match_cnt,
  output logic [31:0]       err_cnt,
  output logic              overflow,
  output logic              timeout
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, STUCK} state_t;

  typedef struct packed {
    instruction_item_t inst;
    data_item_t        res;
  } mdl_entry_t;

  mdl_entry_t       mdl_mem_q [DEPTH];
  data_item_t       dut_mem_q [DEPTH];
  logic [AW:0]      mdl_wr_q, mdl_rd_q, dut_wr_q, dut_rd_q;
  state_t           state_q;
  logic [CW-1:0]    idle_cnt_q;
  logic             err_valid_q, overflow_q, timeout_q;
  error_data_item_t err_item_q;
  logic [31:0]      match_cnt_q, err_cnt_q;

  logic       mdl_empty, mdl_full, dut_empty, dut_full;
  logic       mdl_push, dut_push, dut_drop, pop;
  mdl_entry_t mdl_head;
  data_item_t dut_head;
  logic [2:0] champ;

  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  // Extra wrap bit distinguishes full from empty when the indices coincide.
  assign mdl_empty = (mdl_wr_q == mdl_rd_q);
  assign mdl_full  = (mdl_wr_q[AW-1:0] == mdl_rd_q[AW-1:0]) && (mdl_wr_q[AW] != mdl_rd_q[AW]);
  assign dut_empty = (dut_wr_q == dut_rd_q);
  assign dut_full  = (dut_wr_q[AW-1:0] == dut_rd_q[AW-1:0]) && (dut_wr_q[AW] != dut_rd_q[AW]);

  assign mdl_ready = !mdl_full;
  assign pop       = !mdl_empty && !dut_empty;
  assign mdl_push  = mdl_valid && mdl_ready;
  assign dut_push  = dut_valid && (!dut_full || pop);
  assign dut_drop  = dut_valid && dut_full && !pop;

  assign mdl_head = mdl_mem_q[mdl_rd_q[AW-1:0]];
  assign dut_head = dut_mem_q[dut_rd_q[AW-1:0]];
  assign champ    = {mdl_head.res.write != dut_head.write,
                     mdl_head.res.addr  != dut_head.addr,
                     mdl_head.res.data  != dut_head.data};

  always_ff @(posedge clk) begin
    if (mdl_push) mdl_mem_q[mdl_wr_q[AW-1:0]] <= '{inst: mdl_inst, res: mdl_res};
    if (dut_push) dut_mem_q[dut_wr_q[AW-1:0]] <= dut_res;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mdl_wr_q    <= '0;
      mdl_rd_q    <= '0;
      dut_wr_q    <= '0;
      dut_rd_q    <= '0;
      state_q     <= IDLE;
      idle_cnt_q  <= '0;
      err_valid_q <= 1'b0;
      err_item_q  <= '0;
      match_cnt_q <= '0;
      err_cnt_q   <= '0;
      overflow_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      if (mdl_push) mdl_wr_q <= mdl_wr_q + PTR_ONE;
      if (dut_push) dut_wr_q <= dut_wr_q + PTR_ONE;
      if (dut_drop) overflow_q <= 1'b1;
      err_valid_q <= pop && (champ != 3'b000);
      if (pop) begin
        mdl_rd_q <= mdl_rd_q + PTR_ONE;
        dut_rd_q <= dut_rd_q + PTR_ONE;
        if (champ != 3'b000) begin
          err_item_q <= '{input_instruction: mdl_head.inst, model_result: mdl_head.res,
                          dut_result: dut_head, error_champ: champ};
          err_cnt_q  <= sat_inc(err_cnt_q);
        end else begin
          match_cnt_q <= sat_inc(match_cnt_q);
        end
      end
      case (state_q)
        IDLE: begin
          if (mdl_empty != dut_empty) begin
            state_q    <= WAIT;
            idle_cnt_q <= '0;
          end
        end
        WAIT: begin
          if (mdl_empty && dut_empty) begin
            state_q <= IDLE;
          end else if (pop) begin
            idle_cnt_q <= '0;
          end else begin
            idle_cnt_q <= idle_cnt_q + CNT_ONE;
            if (idle_cnt_q == CNT_LAST) begin
              timeout_q <= 1'b1;
              state_q   <= STUCK;
            end
          end
        end
        STUCK: begin
          if (mdl_empty && dut_empty) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign err_valid = err_valid_q;
  assign err_item  = err_item_q;
  assign match_cnt = match_cnt_q;
  assign err_cnt   = err_cnt_q;
  assign overflow  = overflow_q;
  assign timeout   = timeout_q;
endmodule
